button_event_detector: RTL and testbench
========================================

Name: button_event_detector

Overview:
- Consumes the slow, debounced button level from the debouncer stage.
- Turns that level into single-cycle event pulses: press, release, short press, long press and optional auto-repeat. Also keeps a wrap-around press counter.
- Sits between the debouncer and the lab's control and display logic, so downstream blocks never edge-detect raw levels themselves.

Parameters:
- LONG_PRESS_CYCLES, 50_000_000, clock cycles of continuous hold from the press event to long_pulse; must be ≥2 and fit in CNT_W.
- REPEAT_CYCLES, 10_000_000, clock cycles between repeat pulses after long_pulse; must be ≥2 and fit in CNT_W.
- CNT_W, 27, width of the internal hold/repeat counter.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  debounced button level; 1 = pressed; already in the clock domain.
- press_pulse  output  1  one-cycle pulse on an accepted press.
- release_pulse  output  1  one-cycle pulse on any release from PRESSED or HELD.
- short_pulse  output  1  one-cycle pulse on a release before the long threshold.
- long_pulse  output  1  one-cycle pulse when the long threshold is reached.
- repeat_pulse  output  1  one-cycle auto-repeat pulse.
- held  output  1  high while in PRESSED or HELD.
- press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- All outputs are registered; each has a reset value of 0.
- States: WAIT_RELEASE, IDLE, PRESSED, HELD. Reset forces WAIT_RELEASE and clears the counter and press_count.
- Edge N is defined as the first rising edge that samples btn_in=1 while in IDLE.
- WAIT_RELEASE:
  - btn_in=0 → IDLE.
  - Otherwise stay, with no events.
  - A button held through reset never generates a press.
- IDLE:
  - btn_in=1 → PRESSED.
  - press_pulse=1 for the cycle after edge N.
  - Counter <= 0; press_count <= press_count+1, wrapping 255→0.
- PRESSED:
  - btn_in=0 → IDLE, with release_pulse=1 and short_pulse=1.
  - Else if counter==LONG_PRESS_CYCLES-1 → HELD, with long_pulse=1 and counter <= 0.
  - Else counter++.
  - Result: long_pulse is high in the cycle after edge N+LONG_PRESS_CYCLES.
- HELD:
  - btn_in=0 → IDLE, with release_pulse=1 (short_pulse stays 0).
  - Otherwise, repeat behaviour per the optional feature.
- Simultaneous release and terminal count: release wins → short_pulse only, no long_pulse.
- held is 1 in PRESSED and HELD, and 0 otherwise.
- At most one of press, long or repeat pulses in any cycle; release_pulse and short_pulse may coincide.
- Reset mid-operation: the next cycle has all pulses 0, held=0, press_count=0, state WAIT_RELEASE. No release_pulse is emitted for the aborted press.
- The counter never exceeds the active terminal value minus 1, so there is no overflow.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - HELD counts each cycle.
  - At counter==REPEAT_CYCLES-1 with btn_in=1: repeat_pulse=1 and counter <= 0.
  - Repeats land after edges N+LONG_PRESS_CYCLES+k·REPEAT_CYCLES, k≥1.
  - Release on the terminal cycle wins: no repeat_pulse.
- Undefined:
  - repeat_pulse is tied to 0.
  - The counter holds in HELD.
  - The REPEAT_CYCLES parameter is accepted but unused.

Decomposition:
- Package btn_event_pkg:
  - 2-bit state encoding: WAIT_RELEASE=0, IDLE=1, PRESSED=2, HELD=3.
  - Default cycle constants for 100 MHz: 0.5 s long press, 0.1 s repeat.
  - PRESS_CNT_W=8.
- Single module; the counter and FSM are inline. No sub-module is warranted.

Test Plan:
All scenarios use LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
- Hold btn_in=1 through reset, release 5 cycles after reset deasserts → no pulses, press_count=0, state reaches IDLE.
- Press at edge N, release after 3 cycles → press_pulse at N; release_pulse and short_pulse together at release; press_count=1; long_pulse never fires.
- Hold for 21 cycles:
  - press at N, long at N+8.
  - With BTN_AUTO_REPEAT_EN: repeat at N+12, N+16, N+20.
  - Without it: repeat_pulse stays 0.
  - On release: release_pulse=1, short_pulse=0.
- btn_in drops at exactly edge N+8 → short_pulse and release_pulse fire, no long_pulse, held falls.
- 256 short presses → press_count returns to 0, with 256 press_pulses counted.
- Assert reset while in HELD with btn_in=1:
  - All outputs are 0 the next cycle; no release_pulse.
  - A press after a subsequent release gives press_count=1.

Source files
------------

// File: rtl/btn_event_pkg.sv
// btn_event_pkg
//   Shared types and constants for button_event_detector.
//   - state_t    : 2-bit FSM state encoding
//   - events_t   : bundle of the single-cycle event pulses
//   - DEFAULT_*  : cycle constants for a 100 MHz clock
//                  (0.5 s long press, 0.1 s repeat)
//   - PRESS_CNT_W: width of the wrap-around press counter
package btn_event_pkg;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    PRESSED      = 2'd2,
    HELD         = 2'd3
  } state_t;

  // Pulses that leave the block as registered one-cycle strobes.
  // Repeat is kept separate because it only exists in the auto-repeat build.
  typedef struct packed {
    logic press;
    logic rel;
    logic shrt;
    logic lng;
  } events_t;

  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES     = 10_000_000;
  localparam int unsigned DEFAULT_CNT_W             = 27;
  localparam int unsigned PRESS_CNT_W               = 8;

endpackage : btn_event_pkg

// File: rtl/button_event_detector.sv
// button_event_detector
//   Turns the debounced button level into single-cycle event pulses
//   (press, release, short press, long press, optional auto-repeat) and
//   keeps a modulo-256 count of accepted presses.
//
//   Build option: define BTN_AUTO_REPEAT_EN to emit repeat_pulse every
//   REPEAT_CYCLES while the button stays held after the long-press point.
//   Without it repeat_pulse is constant 0 and REPEAT_CYCLES is unused.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   btn_in        in   debounced button level, 1 = pressed
//   press_pulse   out  one cycle on an accepted press
//   release_pulse out  one cycle on a release from PRESSED or HELD
//   short_pulse   out  one cycle on a release before the long threshold
//   long_pulse    out  one cycle when the long threshold is reached
//   repeat_pulse  out  one cycle per auto-repeat interval
//   held          out  high while in PRESSED or HELD
//   press_count   out  accepted presses, modulo 256
module button_event_detector
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES,
  parameter int unsigned CNT_W             = DEFAULT_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   btn_in,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   short_pulse,
  output logic                   long_pulse,
  output logic                   repeat_pulse,
  output logic                   held,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Elaboration-time sanity checks on the timing parameters.
  if (LONG_PRESS_CYCLES < 2 || 64'(LONG_PRESS_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be >= 2 and fit in CNT_W");
  end
  if (REPEAT_CYCLES < 2 || 64'(REPEAT_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2 and fit in CNT_W");
  end

  // The counter runs from 0 to terminal-1, so it can never overflow.
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PRESS_CNT_W-1:0] count_d;
  events_t                ev_q, ev_d;
  logic                   held_d;
`ifdef BTN_AUTO_REPEAT_EN
  logic                   rpt_q, rpt_d;
`endif

  // State, counter and output registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    // NOTE: only this handful of flops exists, so all of them are reset;
    // the reset is synchronous because the surrounding lab logic is.
    if (reset) begin
      state_q     <= WAIT_RELEASE;
      cnt_q       <= '0;
      press_count <= '0;
      ev_q        <= '0;
      held        <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_count <= count_d;
      ev_q        <= ev_d;
      held        <= held_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  // Next-state, counter and press-count logic.
  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = press_count;
    unique case (state_q)
      WAIT_RELEASE: begin
        // A button still down after reset must be let go before it counts.
        if (!btn_in) state_d = IDLE;
      end
      IDLE: begin
        if (btn_in) begin
          state_d = PRESSED;
          cnt_d   = '0;
          count_d = press_count + PRESS_CNT_W'(1);
        end
      end
      PRESSED: begin
        // Release is tested first so it wins over the terminal count.
        if (!btn_in) begin
          state_d = IDLE;
        end else if (cnt_q == LONG_TERM) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_in) begin
          state_d = IDLE;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (cnt_q == REPEAT_TERM) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  // Event decode: the values the output registers take at this edge.
  always_comb begin
    ev_d   = '0;
    held_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rpt_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        ev_d.press = btn_in;
        held_d     = btn_in;
      end
      PRESSED: begin
        ev_d.rel  = !btn_in;
        ev_d.shrt = !btn_in;
        ev_d.lng  = btn_in && (cnt_q == LONG_TERM);
        held_d    = btn_in;
      end
      HELD: begin
        ev_d.rel = !btn_in;
        held_d   = btn_in;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_d    = btn_in && (cnt_q == REPEAT_TERM);
`endif
      end
      default: ;
    endcase
  end

  assign press_pulse   = ev_q.press;
  assign release_pulse = ev_q.rel;
  assign short_pulse   = ev_q.shrt;
  assign long_pulse    = ev_q.lng;
`ifdef BTN_AUTO_REPEAT_EN
  assign repeat_pulse  = rpt_q;
`else
  assign repeat_pulse  = 1'b0;
`endif

endmodule : button_event_detector

// File: tb/tb_button_event_detector.sv
// tb_button_event_detector
//   Table-driven bench for button_event_detector with LONG_PRESS_CYCLES=8,
//   REPEAT_CYCLES=4, CNT_W=4, plus hand-written multi-cycle sequences.
//   Expected repeat behaviour follows the BTN_AUTO_REPEAT_EN build option.
module tb_button_event_detector;

  localparam int unsigned LONG_N = 8;
  localparam int unsigned RPT_N  = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  // Pulse field order: press, release, short, long, repeat.
  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_PRESS = 5'b10000;
  localparam logic [4:0] P_REL   = 5'b01000;
  localparam logic [4:0] P_SHORT = 5'b00100;
  localparam logic [4:0] P_LONG  = 5'b00010;
  localparam logic [4:0] P_RPT   = 5'b00001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b1;
  logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;

  always #5 clock = ~clock;

  button_event_detector #(
    .LONG_PRESS_CYCLES(LONG_N),
    .REPEAT_CYCLES    (RPT_N),
    .CNT_W            (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       btn;
    logic [4:0] pulses;
    logic       held;
    logic [7:0] count;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input string nm, input logic rst, input logic btn,
                     input logic [4:0] p, input logic h, input int cnt);
    vec_t v;
    v.name   = nm;
    v.rst    = rst;
    v.btn    = btn;
    v.pulses = p;
    v.held   = h;
    v.count  = 8'(cnt);
    vecs.push_back(v);
  endtask

  // Drive inputs mid-cycle, then sample 1 time unit after the rising edge.
  task automatic apply(input logic rst, input logic btn);
    @(negedge clock);
    reset  = rst;
    btn_in = btn;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [13:0] outs();
    return {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse,
            held, press_count};
  endfunction

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (press,rel,short,long,rpt,held,count)",
               nm, got, exp);
    end
  endtask

  task automatic check_excl(input string nm);
    n_cmp++;
    if ($countones({press_pulse, long_pulse, repeat_pulse}) > 1) begin
      n_bad++;
      $display("FAIL %s exclusive: press=%b long=%b repeat=%b, at most one allowed",
               nm, press_pulse, long_pulse, repeat_pulse);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int presses;

    // Button held through reset, released 5 cycles after reset drops.
    for (int i = 0; i < 3; i++) add("rst_hold", 1, 1, P_NONE, 0, 0);
    for (int i = 0; i < 5; i++) add("wait_rel", 0, 1, P_NONE, 0, 0);
    add("to_idle", 0, 0, P_NONE, 0, 0);
    add("idle",    0, 0, P_NONE, 0, 0);

    // Short press: 3 cycles down.
    add("short_press", 0, 1, P_PRESS, 1, 1);
    add("short_hold1", 0, 1, P_NONE,  1, 1);
    add("short_hold2", 0, 1, P_NONE,  1, 1);
    add("short_rel",   0, 0, P_REL | P_SHORT, 0, 1);
    add("short_idle",  0, 0, P_NONE,  0, 1);

    // 21-cycle hold: long at N+8, repeats at N+12/16/20 when enabled.
    for (int k = 0; k <= 20; k++) begin
      logic [4:0] p;
      p = P_NONE;
      if (k == 0) p = P_PRESS;
      else if (k == int'(LONG_N)) p = P_LONG;
      else if (RPT_ON && k > int'(LONG_N) && ((k - int'(LONG_N)) % int'(RPT_N)) == 0) p = P_RPT;
      add($sformatf("hold21_k%0d", k), 0, 1, p, 1, 2);
    end
    add("hold21_rel",  0, 0, P_REL,  0, 2);
    add("hold21_idle", 0, 0, P_NONE, 0, 2);

    // Release exactly on the long terminal edge: release wins.
    add("edge_press", 0, 1, P_PRESS, 1, 3);
    for (int k = 1; k < int'(LONG_N); k++) add("edge_hold", 0, 1, P_NONE, 1, 3);
    add("edge_rel",  0, 0, P_REL | P_SHORT, 0, 3);
    add("edge_idle", 0, 0, P_NONE, 0, 3);

    // Release exactly on the first repeat terminal edge: no repeat pulse.
    add("rtrm_press", 0, 1, P_PRESS, 1, 4);
    for (int k = 1; k < int'(LONG_N + RPT_N); k++)
      add("rtrm_hold", 0, 1, (k == int'(LONG_N)) ? P_LONG : P_NONE, 1, 4);
    add("rtrm_rel",  0, 0, P_REL, 0, 4);
    add("rtrm_idle", 0, 0, P_NONE, 0, 4);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].btn);
      check(vecs[i].name, outs(), {vecs[i].pulses, vecs[i].held, vecs[i].count});
      check_excl(vecs[i].name);
    end

    // 256 short presses wrap the counter back to 0.
    apply(1, 0);
    check("wrap_reset", outs(), 14'd0);
    apply(0, 0);
    presses = 0;
    for (int i = 0; i < 256; i++) begin
      apply(0, 1);
      if (press_pulse) presses++;
      if (i == 0)   check("wrap_first", {6'd0, press_count}, 14'd1);
      if (i == 254) check("wrap_255",   {6'd0, press_count}, 14'd255);
      apply(0, 0);
    end
    check("wrap_count",  {6'd0, press_count}, 14'd0);
    check("wrap_pulses", 14'(presses), 14'd256);

    // Reset while in HELD with the button still down.
    apply(0, 1);
    check("hr_press", outs(), {P_PRESS, 1'b1, 8'd1});
    for (int k = 1; k <= 9; k++) apply(0, 1);
    check("hr_in_held", outs(), {P_NONE, 1'b1, 8'd1});
    apply(1, 1);
    check("hr_reset", outs(), 14'd0);
    apply(0, 1);
    check("hr_wait1", outs(), 14'd0);
    apply(0, 1);
    check("hr_wait2", outs(), 14'd0);
    apply(0, 0);
    check("hr_released", outs(), 14'd0);
    apply(0, 1);
    check("hr_repress", outs(), {P_PRESS, 1'b1, 8'd1});
    apply(0, 0);
    check("hr_rel", outs(), {P_REL | P_SHORT, 1'b0, 8'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_button_event_detector
